// File: rtl/seven_seg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg
// Purpose  : Four-digit multiplexed common-anode seven-segment driver that
//            decodes ASCII characters and scans them onto one segment bus.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg #(
    parameter int CNT_WIDTH = 18
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] display_0,
    input  logic [7:0] display_1,
    input  logic [7:0] display_2,
    input  logic [7:0] display_3,
    input  logic [1:0] decplace,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [7:0]           r_seg;
    logic [3:0]           r_an;

    logic [1:0] w_k;
    logic [7:0] w_char;
    logic [7:0] w_upper;
    logic [6:0] w_code;
    logic [3:0] w_an;
    logic       w_dp;

    assign w_k = r_cnt[CNT_WIDTH-1 -: 2];

    always_comb begin
        w_char = display_0;
        w_an   = 4'b0111;
        case (w_k)
            2'd0: begin w_char = display_0; w_an = 4'b0111; end
            2'd1: begin w_char = display_1; w_an = 4'b1011; end
            2'd2: begin w_char = display_2; w_an = 4'b1101; end
            2'd3: begin w_char = display_3; w_an = 4'b1110; end
            default: begin w_char = display_0; w_an = 4'b0111; end
        endcase
    end

    // Fold lower-case letters onto upper case so one table serves both.
    assign w_upper = ((w_char >= 8'h61) && (w_char <= 8'h7A)) ? (w_char - 8'h20) : w_char;

    always_comb begin
        w_code = 7'h00;
        case (w_upper)
            "0": w_code = 7'h3F;
            "1": w_code = 7'h06;
            "2": w_code = 7'h5B;
            "3": w_code = 7'h4F;
            "4": w_code = 7'h66;
            "5": w_code = 7'h6D;
            "6": w_code = 7'h7D;
            "7": w_code = 7'h07;
            "8": w_code = 7'h7F;
            "9": w_code = 7'h6F;
            "A": w_code = 7'h77;
            "B": w_code = 7'h7C;
            "C": w_code = 7'h39;
            "D": w_code = 7'h5E;
            "E": w_code = 7'h79;
            "F": w_code = 7'h71;
            "G": w_code = 7'h3D;
            "H": w_code = 7'h76;
            "I": w_code = 7'h06;
            "J": w_code = 7'h1E;
            "L": w_code = 7'h38;
            "N": w_code = 7'h54;
            "O": w_code = 7'h5C;
            "P": w_code = 7'h73;
            "R": w_code = 7'h50;
            "S": w_code = 7'h6D;
            "T": w_code = 7'h78;
            "U": w_code = 7'h3E;
            "Y": w_code = 7'h6E;
            "-": w_code = 7'h40;
            "_": w_code = 7'h08;
            " ": w_code = 7'h00;
            default: w_code = 7'h00;
        endcase
    end

    assign w_dp = (w_k == decplace);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
            r_an  <= w_an;
            r_seg <= ~{w_dp, w_code};
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg
// Purpose  : Self-checking bench for seven_seg with a table-driven reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg;

    localparam int CNT_WIDTH = 4;
    localparam int FRAME     = 1 << CNT_WIDTH;
    localparam int DIGIT_LEN = FRAME / 4;

    logic       clk;
    logic       rstn;
    logic [7:0] display_0, display_1, display_2, display_3;
    logic [1:0] decplace;
    logic [7:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;
    int m      = 0;   // refresh count the next edge will see
    logic [6:0] code_tab [256];

    seven_seg #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .display_0 (display_0),
        .display_1 (display_1),
        .display_2 (display_2),
        .display_3 (display_3),
        .decplace  (decplace),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] char_of(input int k);
        case (k)
            0: return display_0;
            1: return display_1;
            2: return display_2;
            default: return display_3;
        endcase
    endfunction

    // One clock edge, then compare against the reference model.
    task automatic step();
        int k;
        logic [7:0] exp_seg;
        logic [3:0] exp_an;
        @(posedge clk);
        k       = m / DIGIT_LEN;
        exp_an  = ~(4'b1000 >> k);
        exp_seg = ~{(k == int'(decplace)), code_tab[char_of(k)]};
        m       = (m + 1) % FRAME;
        #1;
        check("model_an", {4'h0, an}, {4'h0, exp_an});
        check("model_seg", seg, exp_seg);
    endtask

    task automatic set_text(input string s);
        display_0 = s[0];
        display_1 = s[1];
        display_2 = s[2];
        display_3 = s[3];
    endtask

    initial begin
        string       letters;
        logic [6:0]  lv [19];
        logic [6:0]  dv [10];
        logic [7:0]  scan_seg [4];
        logic [3:0]  scan_an [4];
        string       pool;

        for (int i = 0; i < 256; i++) code_tab[i] = 7'h00;
        dv = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        for (int i = 0; i < 10; i++) code_tab[8'h30 + i] = dv[i];
        letters = "ABCDEFGHIJLNOPRSTUY";
        lv = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h06, 7'h1E,
               7'h38, 7'h54, 7'h5C, 7'h73, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h6E};
        for (int i = 0; i < 19; i++) begin
            code_tab[letters[i]]         = lv[i];
            code_tab[letters[i] + 8'h20] = lv[i];
        end
        code_tab[8'h2D] = 7'h40;
        code_tab[8'h5F] = 7'h08;
        code_tab[8'h20] = 7'h00;

        // Reset values, asserted between edges.
        rstn = 1'b1;
        set_text("0123");
        decplace = 2'd2;
        #2 rstn = 1'b0;
        #1;
        check("reset_async_an", {4'h0, an}, 8'h0F);
        check("reset_async_seg", seg, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_an", {4'h0, an}, 8'h0F);
        check("reset_hold_seg", seg, 8'hFF);

        // Scan order "0123", dp on digit 2, across more than one frame.
        scan_seg = '{8'hC0, 8'hF9, 8'h24, 8'hB0};
        scan_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        rstn = 1'b1;
        m    = 0;
        for (int i = 0; i < FRAME + DIGIT_LEN + 1; i++) begin
            int k;
            k = (i % FRAME) / DIGIT_LEN;
            step();
            check("scan_an", {4'h0, an}, {4'h0, scan_an[k]});
            check("scan_seg", seg, scan_seg[k]);
        end

        // Letters, mixed case, dp on digit 0.
        set_text("CSoC");
        decplace = 2'd0;
        while (m != 0) step();
        scan_seg = '{8'h46, 8'h92, 8'hA3, 8'hC6};
        for (int i = 0; i < FRAME; i++) begin
            step();
            check("letter_seg", seg, scan_seg[i / DIGIT_LEN]);
        end

        // Blank codes and a dp on the last digit.
        display_1 = 8'h00;
        display_2 = "K";
        display_3 = "7";
        decplace  = 2'd3;
        for (int i = 0; i < FRAME; i++) step();
        while (m != DIGIT_LEN + 1) step();
        check("blank_nul", seg, 8'hFF);
        while (m != 2 * DIGIT_LEN + 1) step();
        check("blank_k", seg, 8'hFF);
        while (m != 3 * DIGIT_LEN + 1) step();
        check("digit3_dp", seg, 8'h78);

        // Live change in the middle of digit 0.
        display_0 = "1";
        decplace  = 2'd1;
        for (int i = 0; i < FRAME && m != 2; i++) step();
        step();
        check("live_before", seg, 8'hF9);
        display_0 = "8";
        step();
        check("live_after", seg, 8'h80);

        // Reset in the middle of digit 2, between edges.
        for (int i = 0; i < FRAME && m != 2 * DIGIT_LEN + 2; i++) step();
        check("mid_an_pre", {4'h0, an}, 8'h0D);
        #2 rstn = 1'b0;
        #1;
        check("mid_reset_an", {4'h0, an}, 8'h0F);
        check("mid_reset_seg", seg, 8'hFF);
        @(posedge clk);
        #1 rstn = 1'b1;
        m = 0;
        step();
        check("post_reset_an", {4'h0, an}, 8'h07);

        // Randomised inputs against the model.
        pool = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz-_ ";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [7:0] c;
                if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(0, 255));
                else c = pool[$urandom_range(0, pool.len() - 1)];
                case ($urandom_range(0, 3))
                    0: display_0 = c;
                    1: display_1 = c;
                    2: display_2 = c;
                    default: display_3 = c;
                endcase
            end
            if ($urandom_range(0, 7) == 0) decplace = 2'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
